// File: rtl/memory_instruction_pipelined.sv
// memory_instruction_pipelined: byte-writable instruction store with a stallable valid/ready fetch pipeline
module memory_instruction_pipelined #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_BITS    = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_fetch_req,
    input  logic [ADDR_BITS-1:0]    i_fetch_addr,
    output logic                    o_fetch_ready,
    output logic                    o_fetch_valid,
    output logic [DATA_WIDTH-1:0]   o_fetch_data,
    output logic                    o_fetch_error,
    input  logic                    i_fetch_accept,
    input  logic                    i_write_enable,
    input  logic [ADDR_BITS-1:0]    i_write_addr,
    input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
    input  logic [DATA_WIDTH-1:0]   i_data_in
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [READ_LATENCY-1:0]                 r_valid;
    logic [READ_LATENCY-1:0]                 r_error;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_data;

    logic                  w_advance;
    logic                  w_accept;
    logic                  w_fetch_in_range;
    logic                  w_write_in_range;
    logic [DATA_WIDTH-1:0] w_read_data;

    assign w_advance        = !o_fetch_valid || i_fetch_accept;
    assign w_accept         = i_fetch_req && w_advance;
    assign w_fetch_in_range = 32'(i_fetch_addr) < DEPTH;
    assign w_write_in_range = 32'(i_write_addr) < DEPTH;
    assign w_read_data      = w_fetch_in_range ? r_mem[i_fetch_addr[AW-1:0]] : '0;

    assign o_fetch_ready = w_advance;
    assign o_fetch_valid = r_valid[READ_LATENCY-1];
    assign o_fetch_error = r_error[READ_LATENCY-1];
    assign o_fetch_data  = r_data[READ_LATENCY-1];

    // Program port: byte-lane write; array is never reset, and the fetch reads the pre-edge word (read-first)
    always_ff @(posedge i_clock) begin
        if (i_write_enable && w_write_in_range)
            for (int b = 0; b < NB; b++)
                if (i_byte_enable[b])
                    r_mem[i_write_addr[AW-1:0]][8*b +: 8] <= i_data_in[8*b +: 8];
    end

    // Fetch pipeline: all stages shift together when the output is free or being taken, otherwise hold
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
            r_error <= '0;
            r_data  <= '0;
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            r_error[0] <= w_accept && !w_fetch_in_range;
            r_data[0]  <= w_accept ? w_read_data : '0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_error[s] <= r_error[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end
endmodule

// File: tb/tb_memory_instruction_pipelined.sv
// tb_memory_instruction_pipelined: directed vectors with a queue scoreboard on the fetch output
module tb_memory_instruction_pipelined;
    logic        clk = 0;
    logic        rst = 1;
    logic        fetch_req = 0;
    logic [7:0]  fetch_addr = 0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_error;
    logic        fetch_accept = 1;
    logic        write_enable = 0;
    logic [7:0]  write_addr = 0;
    logic [3:0]  byte_enable = 0;
    logic [31:0] data_in = 0;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q [$];
    logic        last_got;
    logic [31:0] snap;

    memory_instruction_pipelined #(
        .DATA_WIDTH(32), .ADDR_BITS(8), .DEPTH(200), .READ_LATENCY(2)
    ) dut (
        .i_clock(clk), .i_reset(rst),
        .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_ready(fetch_ready), .o_fetch_valid(fetch_valid),
        .o_fetch_data(fetch_data), .o_fetch_error(fetch_error),
        .i_fetch_accept(fetch_accept),
        .i_write_enable(write_enable), .i_write_addr(write_addr),
        .i_byte_enable(byte_enable), .i_data_in(data_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Inputs change 2 time units after posedge; acceptance is judged at negedge, then we return to posedge+2
    task automatic cyc(input logic req, input logic [7:0] a, input logic [31:0] ed, input logic ee, input logic acc);
        fetch_req = req;
        fetch_addr = a;
        fetch_accept = acc;
        @(negedge clk);
        last_got = req && fetch_ready;
        if (last_got) exp_q.push_back({ee, ed});
        @(posedge clk);
        #2;
        write_enable = 0;
        fetch_req = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        write_enable = 1;
        write_addr = a;
        byte_enable = be;
        data_in = d;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic drain;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc(0, 0, 0, 0, 1);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the output is handed over, and checks idle outputs are zero
    always @(negedge clk) begin
        if (!rst) begin
            if (fetch_valid && fetch_accept) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {31'b0, fetch_valid}, 0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("fetch_data", fetch_data, e[31:0]);
                    chk("fetch_error", {31'b0, fetch_error}, {31'b0, e[32]});
                end
            end else if (!fetch_valid) begin
                chk("idle_data_zero", fetch_data, 0);
                chk("idle_error_zero", {31'b0, fetch_error}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_valid", {31'b0, fetch_valid}, 0);
        chk("rst_data", fetch_data, 0);
        chk("rst_error", {31'b0, fetch_error}, 0);
        chk("rst_ready", {31'b0, fetch_ready}, 1);
        @(posedge clk);
        #2;
        rst = 0;
        wr(8'h05, 4'hF, 32'hDEADBEEF);
        cyc(1, 8'h05, 32'hDEADBEEF, 0, 1);
        chk("lat2_not_yet", {31'b0, fetch_valid}, 0);
        cyc(0, 0, 0, 0, 1);
        chk("lat2_valid", {31'b0, fetch_valid}, 1);
        chk("lat2_data", fetch_data, 32'hDEADBEEF);
        wr(8'h10, 4'hF, 32'h11223344);
        wr(8'h10, 4'b0101, 32'hAABBCCDD);
        cyc(1, 8'h10, 32'h11BB33DD, 0, 1);
        cyc(1, 8'hC8, 32'h0, 1, 1);
        wr(8'hC8, 4'hF, 32'hFFFFFFFF);
        cyc(1, 8'h00, 32'h0, 0, 1);
        wr(8'h07, 4'h0, 32'hFFFFFFFF);
        cyc(1, 8'h07, 32'h0, 0, 1);
        write_enable = 1;
        write_addr = 8'h20;
        byte_enable = 4'hF;
        data_in = 32'h12345678;
        cyc(1, 8'h20, 32'h0, 0, 1);
        cyc(1, 8'h20, 32'h12345678, 0, 1);
        drain();
        for (int k = 0; k < 8; k++) wr(8'(k), 4'hF, 32'hA0000000 + k);
        begin
            int i = 0;
            for (int c = 0; c < 40 && i < 8; c++) begin
                if (c == 3) snap = fetch_data;
                cyc(1, 8'(i), 32'hA0000000 + i, 0, !(c >= 3 && c <= 5));
                if (last_got) i++;
                if (c >= 3 && c <= 5) begin
                    chk("stall_valid", {31'b0, fetch_valid}, 1);
                    chk("stall_data", fetch_data, snap);
                    chk("stall_ready", {31'b0, fetch_ready}, 0);
                end
            end
            chk("stream_issued", i, 8);
        end
        fetch_accept = 1;
        drain();
        cyc(1, 8'h10, 32'h11BB33DD, 0, 1);
        cyc(1, 8'h20, 32'h12345678, 0, 1);
        chk("inflight_valid", {31'b0, fetch_valid}, 1);
        rst = 1;
        #1;
        exp_q.delete();
        chk("async_rst_valid", {31'b0, fetch_valid}, 0);
        chk("async_rst_data", fetch_data, 0);
        chk("async_rst_error", {31'b0, fetch_error}, 0);
        chk("async_rst_ready", {31'b0, fetch_ready}, 1);
        @(posedge clk);
        #2;
        rst = 0;
        cyc(1, 8'h10, 32'h11BB33DD, 0, 1);
        chk("post_rst_accept", {31'b0, last_got}, 1);
        cyc(1, 8'h03, 32'hA0000003, 0, 1);
        drain();
        cyc(0, 0, 0, 0, 1);
        chk("no_replay", {31'b0, fetch_valid}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
